inst_sram_responder: RTL and testbench

- Instruction-memory responder; the slave end of the IFU fetch interface.
- Accepts a fetch address on the pc/pvalid/pready channel and waits a fixed, parameterised latency.
- Returns one 32-bit word on the rdata/rresp/rvalid/rready channel.
- Backed by a word-addressed SRAM array with a bench/boot preload write port; sits between the IFU and the rest of the simulation top.

---
 rtl/inst_sram_pkg.sv | 16 +
 rtl/inst_sram_responder_if.sv | 24 ++
 rtl/inst_sram_responder_isram_array.sv | 35 +++
 rtl/inst_sram_responder.sv | 118 +++++++++++
 tb/tb_inst_sram_responder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/inst_sram_pkg.sv
// Shared types and constants for the instruction SRAM responder.
package inst_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/inst_sram_responder_if.sv
// IFU fetch channel: address request (pc/pvalid/pready) and word response.
interface inst_sram_responder_if;

    logic [31:0] pc;
    logic        pvalid;
    logic        pready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    // IFU side
    modport master (
        output pc, pvalid, rready,
        input  pready, rdata, rresp, rvalid
    );

    // Memory side
    modport slave (
        input  pc, pvalid, rready,
        output pready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/inst_sram_responder_isram_array.sv
// DEPTH x 32 word array: one preload write port, one registered read port.
// The read register doubles as the responder's rdata output; rd_clr zeroes it.
module isram_array #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          rd_clr,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Preload write; contents survive reset.
    always_ff @(posedge clock) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Registered read; a same-edge write is not visible (read-before-write).
    always_ff @(posedge clock) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-memory responder: accepts one fetch address, waits LATENCY
// cycles, then returns a decoded word/response until the IFU accepts it.
module inst_sram_responder
    import inst_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    inst_sram_responder_if.slave     bus,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("inst_sram_responder: LATENCY must be in 1..15");
    end
    if ((1 << AW) != DEPTH) begin : g_bad_depth
        $error("inst_sram_responder: DEPTH must be a power of two");
    end

    state_t      state;
    logic [3:0]  count;
    logic [31:0] addr_q;

    logic [31:0] dec_addr;
    logic [31:0] dec_off;
    logic [1:0]  dec_resp;
    logic        enter;
    logic        rd_en;
    logic        rd_clr;

    // Decode the address being answered: the live pc on a LATENCY==1
    // handshake, otherwise the captured address.
    always_comb begin
        dec_addr = (state == IDLE) ? bus.pc : addr_q;
        dec_off  = dec_addr - BASE_ADDR;
        if (dec_addr[1:0] != 2'b00) begin
            dec_resp = RESP_SLVERR;
        end else if (dec_off >= SPAN) begin
            dec_resp = RESP_DECERR;
        end else begin
            dec_resp = RESP_OKAY;
        end
    end

    // RESP-entry edge detection and array read/clear control.
    // The WAIT exit tests count==0 so that entry lands on edge T+LATENCY.
    always_comb begin
        enter  = ((state == IDLE) && bus.pvalid && bus.pready && (LATENCY == 1))
              || ((state == WAIT) && (count == 4'd0));
        rd_en  = enter && (dec_resp == RESP_OKAY);
        rd_clr = reset || (enter && (dec_resp != RESP_OKAY));
    end

    // Fetch FSM with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            addr_q     <= '0;
            bus.pready <= 1'b1;
            bus.rvalid <= 1'b0;
            bus.rresp  <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pvalid && bus.pready) begin
                        addr_q     <= bus.pc;
                        bus.pready <= 1'b0;
                        count      <= 4'(LATENCY - 1);
                        state      <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rready) begin
                        bus.rvalid <= 1'b0;
                        bus.rresp  <= RESP_OKAY;
                        bus.pready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enter) begin
                bus.rvalid <= 1'b1;
                bus.rresp  <= dec_resp;
            end
        end
    end

    isram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clock   (clock),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_clr  (rd_clr),
        .rd_en   (rd_en),
        .rd_idx  (dec_off[AW+1:2]),
        .rd_data (bus.rdata)
    );

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder (LATENCY=2, DEPTH=4096).
module tb_inst_sram_responder;

    localparam int LATENCY = 2;

    logic        clock;
    logic        reset;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    int n_vec;
    int n_err;
    int cyc;

    inst_sram_responder_if bus();

    inst_sram_responder #(
        .BASE_ADDR (32'h3000_0000),
        .DEPTH     (4096),
        .LATENCY   (LATENCY)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        int          hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clock); #1;
        ld_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int hold, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input bit collide, output int hs_cyc);
        int k;
        hs_cyc = -1;
        bus.pc = a; bus.pvalid = 1'b1; bus.rready = (hold == 0);
        k = 0;
        while (bus.pready !== 1'b1 && k < 50) begin
            @(posedge clock); #1; k++;
        end
        if (bus.pready !== 1'b1) begin
            check("pready_timeout", bus.pready, 32'd1);
            bus.pvalid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        hs_cyc = cyc;
        bus.pvalid = 1'b0;
        bus.pc = ~a;
        check("pready_busy", bus.pready, 32'd0);
        k = 0;
        while (bus.rvalid !== 1'b1 && k < 50) begin
            if (collide && k == LATENCY - 1) begin
                ld_en = 1'b1; ld_addr = 12'd0; ld_data = 32'hDEAD_BEEF;
            end
            @(posedge clock); #1; k++;
            ld_en = 1'b0;
        end
        check("latency", k, LATENCY);
        if (bus.rvalid !== 1'b1) return;
        check("rdata", bus.rdata, exp_d);
        check("rresp", bus.rresp, exp_r);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check("hold_rvalid", bus.rvalid, 32'd1);
            check("hold_rdata", bus.rdata, exp_d);
            check("hold_rresp", bus.rresp, exp_r);
            check("hold_pready", bus.pready, 32'd0);
        end
        bus.rready = 1'b1;
        @(posedge clock); #1;
        check("done_rvalid", bus.rvalid, 32'd0);
        check("done_pready", bus.pready, 32'd1);
        check("done_rresp", bus.rresp, 32'd0);
        check("done_rdata_kept", bus.rdata, exp_d);
        bus.rready = 1'b0;
    endtask

    initial begin
        int hs, prev_hs;
        bit rose;
        n_vec = 0; n_err = 0; cyc = 0;
        clock = 1'b0; reset = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        bus.pc = '0; bus.pvalid = 1'b0; bus.rready = 1'b0;

        vecs[0] = '{32'h3000_0000, 0, 32'h0000_0413, 2'b00};
        vecs[1] = '{32'h3000_0004, 0, 32'h0010_0073, 2'b00};
        vecs[2] = '{32'h3000_3FFC, 5, 32'hCAFE_F00D, 2'b00};
        vecs[3] = '{32'h3000_0002, 0, 32'h0000_0000, 2'b10};
        vecs[4] = '{32'h3000_4000, 0, 32'h0000_0000, 2'b11};
        vecs[5] = '{32'h2FFF_FFFC, 0, 32'h0000_0000, 2'b11};
        vecs[6] = '{32'h3000_4002, 1, 32'h0000_0000, 2'b10};
        vecs[7] = '{32'hFFFF_FFFC, 0, 32'h0000_0000, 2'b11};
        vecs[8] = '{32'h3000_0004, 0, 32'h0010_0073, 2'b00};

        @(posedge clock); #1;
        preload(12'd0, 32'h0000_0413);
        preload(12'd1, 32'h0010_0073);
        preload(12'd4095, 32'hCAFE_F00D);
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;

        check("rst_pready", bus.pready, 32'd1);
        check("rst_rvalid", bus.rvalid, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_rresp", bus.rresp, 32'd0);

        prev_hs = -1;
        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i].pc, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_rresp, 1'b0, hs);
            if (i > 0 && prev_hs >= 0 && hs >= 0)
                check("handshake_gap", hs - prev_hs, LATENCY + 2 + vecs[i-1].hold);
            prev_hs = hs;
        end

        // Reset one cycle after the handshake aborts the fetch.
        bus.pc = 32'h3000_0000; bus.pvalid = 1'b1; bus.rready = 1'b1;
        @(posedge clock); #1;
        bus.pvalid = 1'b0;
        check("abort_accepted", bus.pready, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_pready", bus.pready, 32'd1);
        check("abort_rdata", bus.rdata, 32'd0);
        rose = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            if (bus.rvalid !== 1'b0) rose = 1'b1;
        end
        check("abort_no_rvalid", 32'(rose), 32'd0);
        bus.rready = 1'b0;
        fetch(32'h3000_0000, 0, 32'h0000_0413, 2'b00, 1'b0, hs);

        // Preload hitting the word on its RESP-entry edge returns the old word.
        fetch(32'h3000_0000, 0, 32'h0000_0413, 2'b00, 1'b1, hs);
        fetch(32'h3000_0000, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, hs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
